// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: instruction-in / decoded-result-out handshake bundle for alu_ctrl_pipe
interface alu_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [1:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic [1:0]  cls;
  logic        illegal;
  logic [4:0]  rd_idx;
  logic [4:0]  rn_idx;
  logic [4:0]  rm_idx;
  modport master (
    output in_valid, instr, alu_op, out_ready,
    input  in_ready, out_valid, alu_ctrl, cls, illegal, rd_idx, rn_idx, rm_idx
  );
  modport slave (
    input  in_valid, instr, alu_op, out_ready,
    output in_ready, out_valid, alu_ctrl, cls, illegal, rd_idx, rn_idx, rm_idx
  );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: pipelined LEGv8 ALU control decoder with per-class saturating counters
module alu_ctrl_pipe #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_ctrl_if.slave        bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_d,
  output logic [CNT_W-1:0] cnt_cbz,
  output logic [CNT_W-1:0] cnt_r,
  output logic [CNT_W-1:0] cnt_ill
);
  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [1:0] cls;
    logic [4:0] rd;
    logic [4:0] rn;
    logic [4:0] rm;
  } pay_t;
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("alu_ctrl_pipe: DEPTH must be in 1..4");
  end
  logic [DEPTH-1:0] v;
  pay_t             p [DEPTH];
  pay_t             dec;
  logic [3:0]       r_ctrl;
  logic             adv;
  logic             fire;
  assign adv          = !v[DEPTH-1] || bus.out_ready;
  assign fire         = v[DEPTH-1] && bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.alu_ctrl  = p[DEPTH-1].alu_ctrl;
  assign bus.cls       = p[DEPTH-1].cls;
  assign bus.illegal   = p[DEPTH-1].cls == 2'd3;
  assign bus.rd_idx    = p[DEPTH-1].rd;
  assign bus.rn_idx    = p[DEPTH-1].rn;
  assign bus.rm_idx    = p[DEPTH-1].rm;
  // R-type opcode bits 27:25 select the operation; 1111 marks anything unsupported
  always_comb begin
    r_ctrl = bus.instr[27:25] == 3'b000 ? 4'b0010 :
             bus.instr[27:25] == 3'b010 ? 4'b0110 :
             bus.instr[27:25] == 3'b100 ? 4'b0000 :
             bus.instr[27:25] == 3'b101 ? 4'b0001 : 4'b1111;
    dec.alu_ctrl = bus.alu_op == 2'b00 ? 4'b0010 :
                   bus.alu_op == 2'b01 ? 4'b0111 :
                   bus.alu_op == 2'b10 ? r_ctrl  : 4'b1111;
    dec.cls = (bus.alu_op == 2'b10 && r_ctrl == 4'b1111) ? 2'd3 : bus.alu_op;
    dec.rd  = bus.instr[4:0];
    dec.rn  = bus.instr[9:5];
    dec.rm  = bus.instr[20:16];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) p[k] <= '0;
    end else if (adv) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        v[k] <= v[k-1];
        p[k] <= p[k-1];
      end
      v[0] <= bus.in_valid;
      p[0] <= dec;
    end
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic hit);
    return (hit && !(&c)) ? c + CNT_W'(1) : c;
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst || cnt_clr) begin
      cnt_d   <= '0;
      cnt_cbz <= '0;
      cnt_r   <= '0;
      cnt_ill <= '0;
    end else begin
      cnt_d   <= bump(cnt_d,   fire && bus.cls == 2'd0);
      cnt_cbz <= bump(cnt_cbz, fire && bus.cls == 2'd1);
      cnt_r   <= bump(cnt_r,   fire && bus.cls == 2'd2);
      cnt_ill <= bump(cnt_ill, fire && bus.cls == 2'd3);
    end
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// tb_alu_ctrl_pipe: randomized and directed checks of alu_ctrl_pipe against a decode-table model
module tb_alu_ctrl_pipe;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic s_clr;
  logic [15:0] cnt_d, cnt_cbz, cnt_r, cnt_ill;
  logic [3:0]  s_d, s_cbz, s_r, s_ill;
  always #5 clk = ~clk;
  alu_ctrl_if b ();
  alu_ctrl_if s ();
  alu_ctrl_pipe #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(b), .cnt_clr(clr),
    .cnt_d(cnt_d), .cnt_cbz(cnt_cbz), .cnt_r(cnt_r), .cnt_ill(cnt_ill)
  );
  alu_ctrl_pipe #(.DEPTH(2), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .bus(s), .cnt_clr(s_clr),
    .cnt_d(s_d), .cnt_cbz(s_cbz), .cnt_r(s_r), .cnt_ill(s_ill)
  );
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mc[4];
  // item layout: {present, alu_ctrl[3:0], cls[1:0], illegal, rd, rn, rm}
  logic [22:0] exp_q[$];
  logic [22:0] exp_done[$];
  logic [22:0] got_q[$];
  int fire_cyc[$];

  function automatic logic [22:0] model(input logic [1:0] op, input logic [31:0] ins);
    logic [3:0] a;
    logic [1:0] c;
    a = 4'hf;
    c = 2'd3;
    if (op == 2'b00) begin a = 4'h2; c = 2'd0; end
    if (op == 2'b01) begin a = 4'h7; c = 2'd1; end
    if (op == 2'b10) begin
      case (ins[27:25])
        3'b000: begin a = 4'h2; c = 2'd2; end
        3'b010: begin a = 4'h6; c = 2'd2; end
        3'b100: begin a = 4'h0; c = 2'd2; end
        3'b101: begin a = 4'h1; c = 2'd2; end
        default: begin a = 4'hf; c = 2'd3; end
      endcase
    end
    return {1'b1, a, c, c == 2'd3, ins[4:0], ins[9:5], ins[20:16]};
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] op3, input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
    logic [31:0] w;
    w = $urandom;
    w[27:25] = op3;
    w[4:0] = rd;
    w[9:5] = rn;
    w[20:16] = rm;
    return w;
  endfunction

  function automatic logic [22:0] dut_item();
    return {1'b1, b.alu_ctrl, b.cls, b.illegal, b.rd_idx, b.rn_idx, b.rm_idx};
  endfunction

  task automatic clear_sb();
    exp_done.delete();
    got_q.delete();
    fire_cyc.delete();
  endtask

  // one clock: record handshakes just before the edge, return at the next falling edge
  task automatic step();
    #1;
    if (b.in_valid && b.in_ready) exp_q.push_back(model(b.alu_op, b.instr));
    if (b.out_valid && b.out_ready) begin
      got_q.push_back(dut_item());
      fire_cyc.push_back(cyc);
      if (exp_q.size() > 0) begin
        mc[exp_q[0][17:16]]++;
        exp_done.push_back(exp_q.pop_front());
      end else exp_done.push_back('0);
    end
    if (clr) mc = '{0, 0, 0, 0};
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; s_clr = 1'b0;
    b.in_valid = 1'b0; b.instr = '0; b.alu_op = '0; b.out_ready = 1'b1;
    s.in_valid = 1'b0; s.instr = '0; s.alu_op = '0; s.out_ready = 1'b1;
    mc = '{0, 0, 0, 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({b.out_valid, b.alu_ctrl, b.cls, b.illegal, b.rd_idx, b.rn_idx, b.rm_idx} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", {b.out_valid, b.alu_ctrl, b.cls, b.illegal, b.rd_idx, b.rn_idx, b.rm_idx});
    end
    checks++;
    if ({cnt_d, cnt_cbz, cnt_r, cnt_ill} !== 64'd0) begin
      failures++;
      $display("FAIL reset_counters: got %h want 0", {cnt_d, cnt_cbz, cnt_r, cnt_ill});
    end
    step();
    checks++;
    if (b.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", b.in_ready);
    end
  endtask

  task automatic test_sub();
    clear_sb();
    b.out_ready = 1'b1;
    b.in_valid = 1'b1; b.alu_op = 2'b10; b.instr = mk(3'b010, 5'd3, 5'd1, 5'd2);
    step();
    b.in_valid = 1'b0;
    checks++;
    if (b.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sub_latency_early: out_valid got %b want 0", b.out_valid);
    end
    step();
    checks++;
    if ({b.out_valid, b.alu_ctrl, b.cls, b.illegal, b.rd_idx, b.rn_idx, b.rm_idx} !== {1'b1, 4'b0110, 2'd2, 1'b0, 5'd3, 5'd1, 5'd2}) begin
      failures++;
      $display("FAIL sub_result: got v=%b ctrl=%b cls=%0d ill=%b rd=%0d rn=%0d rm=%0d want v=1 ctrl=0110 cls=2 ill=0 3/1/2",
               b.out_valid, b.alu_ctrl, b.cls, b.illegal, b.rd_idx, b.rn_idx, b.rm_idx);
    end
    step();
    checks++;
    if (cnt_r !== 16'd1 || b.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sub_count: cnt_r got %0d out_valid %b want 1 and 0", cnt_r, b.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want [5];
    logic [1:0] ops [5];
    logic [2:0] f3 [5];
    want = '{4'b0010, 4'b0000, 4'b0001, 4'b0010, 4'b0111};
    ops  = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    f3   = '{3'b000, 3'b100, 3'b101, 3'b000, 3'b000};
    clr = 1'b1;
    step();
    clr = 1'b0;
    clear_sb();
    b.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b.in_valid = 1'b1;
      b.alu_op = ops[i];
      b.instr = (ops[i] == 2'b10) ? mk(f3[i], 5'($urandom), 5'($urandom), 5'($urandom)) : $urandom;
      step();
    end
    drain();
    checks++;
    if (got_q.size() != 5) begin
      failures++;
      $display("FAIL b2b_count: got %0d results want 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_q[i][21:18] !== want[i] || got_q[i] !== exp_done[i]) begin
          failures++;
          $display("FAIL b2b_item%0d: got %h want ctrl %b model %h", i, got_q[i], want[i], exp_done[i]);
        end
      end
      checks++;
      if (fire_cyc[4] - fire_cyc[0] != 4) begin
        failures++;
        $display("FAIL b2b_throughput: span got %0d want 4", fire_cyc[4] - fire_cyc[0]);
      end
    end
    checks++;
    if ({cnt_r, cnt_d, cnt_cbz, cnt_ill} !== {16'd3, 16'd1, 16'd1, 16'd0}) begin
      failures++;
      $display("FAIL b2b_counters: got r=%0d d=%0d cbz=%0d ill=%0d want 3/1/1/0", cnt_r, cnt_d, cnt_cbz, cnt_ill);
    end
  endtask

  task automatic test_illegal();
    clr = 1'b1;
    step();
    clr = 1'b0;
    clear_sb();
    b.out_ready = 1'b1;
    b.in_valid = 1'b1; b.alu_op = 2'b11; b.instr = $urandom;
    step();
    b.alu_op = 2'b10; b.instr = mk(3'b111, 5'd9, 5'd10, 5'd11);
    step();
    drain();
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL illegal_count: got %0d results want 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_q[i][21:15] !== {4'b1111, 2'd3, 1'b1} || got_q[i] !== exp_done[i]) begin
          failures++;
          $display("FAIL illegal_item%0d: got %h want ctrl=1111 cls=3 ill=1 model %h", i, got_q[i], exp_done[i]);
        end
      end
    end
    checks++;
    if (cnt_ill !== 16'd2) begin
      failures++;
      $display("FAIL illegal_counter: got %0d want 2", cnt_ill);
    end
  endtask

  task automatic test_stall();
    clear_sb();
    b.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b.in_valid = 1'b1; b.alu_op = 2'($urandom); b.instr = $urandom;
      step();
    end
    checks++;
    if (exp_q.size() != 2) begin
      failures++;
      $display("FAIL stall_fill: accepted %0d want 2", exp_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      b.in_valid = 1'b1; b.alu_op = 2'($urandom); b.instr = $urandom;
      step();
      checks++;
      if (b.in_ready !== 1'b0 || b.out_valid !== 1'b1 || exp_q.size() == 0 || dut_item() !== exp_q[0]) begin
        failures++;
        $display("FAIL stall_hold%0d: in_ready=%b out_valid=%b item=%h want 0/1/%h", i, b.in_ready, b.out_valid, dut_item(), exp_q.size() ? exp_q[0] : 23'd0);
      end
      checks++;
      if ({cnt_d, cnt_cbz, cnt_r, cnt_ill} !== {16'(mc[0]), 16'(mc[1]), 16'(mc[2]), 16'(mc[3])}) begin
        failures++;
        $display("FAIL stall_counters%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i, cnt_d, cnt_cbz, cnt_r, cnt_ill, mc[0], mc[1], mc[2], mc[3]);
      end
    end
    drain();
    checks++;
    if (got_q.size() != 2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_release: got %0d results, %0d pending want 2 and 0", got_q.size(), exp_q.size());
    end
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_done[i]) begin
        failures++;
        $display("FAIL stall_order%0d: got %h want %h", i, got_q[i], exp_done[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] f3s [5];
    int errs;
    f3s = '{3'b000, 3'b010, 3'b100, 3'b101, 3'b000};
    clear_sb();
    for (int i = 0; i < 300; i++) begin
      b.in_valid = ($urandom % 4) != 0;
      b.out_ready = ($urandom % 4) != 0;
      b.alu_op = 2'($urandom);
      f3s[4] = 3'($urandom);
      b.instr = ($urandom % 2) ? $urandom : mk(f3s[$urandom % 5], 5'($urandom), 5'($urandom), 5'($urandom));
      clr = ($urandom % 32) == 0;
      step();
    end
    clr = 1'b0;
    drain();
    checks++;
    if (got_q.size() != exp_done.size() || exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_count: got %0d results, %0d pending", got_q.size(), exp_q.size());
    end
    errs = 0;
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_done[i]) begin
        failures++;
        errs++;
        if (errs < 5) $display("FAIL random_item%0d: got %h want %h", i, got_q[i], exp_done[i]);
      end
    end
    checks++;
    if ({cnt_d, cnt_cbz, cnt_r, cnt_ill} !== {16'(mc[0]), 16'(mc[1]), 16'(mc[2]), 16'(mc[3])}) begin
      failures++;
      $display("FAIL random_counters: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", cnt_d, cnt_cbz, cnt_r, cnt_ill, mc[0], mc[1], mc[2], mc[3]);
    end
  endtask

  task automatic test_saturation();
    s.out_ready = 1'b1;
    s.alu_op = 2'b10;
    s.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s.instr = mk(3'b000, 5'($urandom), 5'($urandom), 5'($urandom));
      @(posedge clk); @(negedge clk);
    end
    s.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (s_r !== 4'd15 || s_d !== 4'd0) begin
      failures++;
      $display("FAIL sat_value: cnt_r got %0d cnt_d %0d want 15 and 0", s_r, s_d);
    end
    s.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    s.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (s.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL sat_pending: out_valid got %b want 1", s.out_valid);
    end
    s_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    s_clr = 1'b0;
    checks++;
    if (s_r !== 4'd0) begin
      failures++;
      $display("FAIL sat_clear_priority: cnt_r got %0d want 0", s_r);
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    b.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b.in_valid = 1'b1; b.alu_op = 2'b10; b.instr = mk(3'b000, 5'd7, 5'd8, 5'd9);
      step();
    end
    b.in_valid = 1'b0;
    checks++;
    if (b.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_inflight: out_valid got %b want 1", b.out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (b.out_valid !== 1'b0 || {cnt_d, cnt_cbz, cnt_r, cnt_ill} !== 64'd0 || b.alu_ctrl !== 4'd0) begin
      failures++;
      $display("FAIL rst_mid_async: out_valid=%b ctrl=%b counters=%h want 0", b.out_valid, b.alu_ctrl, {cnt_d, cnt_cbz, cnt_r, cnt_ill});
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    clear_sb();
    mc = '{0, 0, 0, 0};
    b.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (got_q.size() != 0 || b.out_valid !== 1'b0 || {cnt_d, cnt_cbz, cnt_r, cnt_ill} !== 64'd0 || b.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_dropped: results=%0d out_valid=%b counters=%h in_ready=%b want 0/0/0/1",
               got_q.size(), b.out_valid, {cnt_d, cnt_cbz, cnt_r, cnt_ill}, b.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_back_to_back();
    test_illegal();
    test_stall();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
